// File: rtl/obstacle_two_src.sv
// Obstacle-two pixel source: sprite RAM addressing, palette lookup and per-frame motion FSM.
// Optional OBSTACLE_MIRROR_EN stores ctrl bit5 and enables a horizontal sprite flip.
module obstacle_two_src #(
    parameter int CD         = 12,
    parameter int SCR_W      = 640,
    parameter int SPR_SIZE   = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic                  frame_tick,
    input  logic                  wr_en,
    input  logic [1:0]            wr_addr,
    input  logic [31:0]           wr_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [1:0]            ram_data,
    output logic [CD-1:0]         rgb,
    output logic                  draw
);

    typedef enum logic [1:0] {IDLE, MOVE, RESPAWN} state_t;

    state_t        state_q, state_d;
    logic [10:0]   x0_q, x0_d, y0_q, y0_d;
    logic          auto_move_q, auto_move_d;
    logic [3:0]    speed_q, speed_d;
    logic [1:0]    transp_q, transp_d;
    logic          mirror_q, mirror_d;
    logic [CD-1:0] pal_q [4];
    logic [CD-1:0] pal_d [4];
    logic          in_rgn_d1_q, in_rgn_d1_d;
    logic [CD-1:0] rgb_q, rgb_d;
    logic          draw_q, draw_d;

    logic          in_rgn, pos_wr, opaque;
    logic [11:0]   x_end, y_end;
    logic [4:0]    col, row, dx;
    logic          unused_wr_bits;

    assign unused_wr_bits = &{1'b0, wr_data[31:28], wr_data[15:12]};

    // Bounds are 12 bits wide so x0/y0 near 2047 do not wrap.
    assign x_end  = {1'b0, x0_q} + 12'(SPR_SIZE);
    assign y_end  = {1'b0, y0_q} + 12'(SPR_SIZE);
    assign in_rgn = (x >= x0_q) && ({1'b0, x} < x_end) &&
                    (y >= y0_q) && ({1'b0, y} < y_end);

    assign dx  = x[4:0] - x0_q[4:0];
    assign row = y[4:0] - y0_q[4:0];
    assign col = mirror_q ? ~dx : dx;
    // Address bus is parked at zero outside the sprite so the RAM sees no spurious toggling.
    assign ram_addr = in_rgn ? ADDR_WIDTH'({row, col}) : '0;

    assign pos_wr = wr_en && (wr_addr == 2'd0);
    assign opaque = in_rgn_d1_q && (ram_data != transp_q);

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        auto_move_d = auto_move_q;
        speed_d     = speed_q;
        transp_d    = transp_q;
        mirror_d    = mirror_q;
        pal_d       = pal_q;
        if (wr_en) begin
            case (wr_addr)
                2'd0: begin
                    x0_d    = wr_data[10:0];
                    y0_d    = wr_data[26:16];
                    state_d = auto_move_q ? MOVE : IDLE;
                end
                2'd1: begin
                    auto_move_d = wr_data[0];
                    speed_d     = wr_data[4:1];
                    transp_d    = wr_data[7:6];
`ifdef OBSTACLE_MIRROR_EN
                    mirror_d    = wr_data[5];
`else
                    mirror_d    = 1'b0;
`endif
                end
                2'd2: begin
                    pal_d[0] = wr_data[CD-1:0];
                    pal_d[1] = wr_data[16+CD-1:16];
                end
                default: begin
                    pal_d[2] = wr_data[CD-1:0];
                    pal_d[3] = wr_data[16+CD-1:16];
                end
            endcase
        end
        // A position write in the same cycle as the tick wins; ctrl written now is used now.
        if (frame_tick && !pos_wr) begin
            case (state_q)
                IDLE: if (auto_move_d) state_d = MOVE;
                MOVE: begin
                    if (!auto_move_d) begin
                        state_d = IDLE;
                    end else if (speed_d != 4'd0) begin
                        if (x0_q > {7'd0, speed_d}) begin
                            x0_d = x0_q - {7'd0, speed_d};
                        end else begin
                            x0_d    = 11'(SCR_W);
                            state_d = RESPAWN;
                        end
                    end
                end
                RESPAWN: begin
                    x0_d    = 11'(SCR_W);
                    state_d = MOVE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_rgn_d1_d = in_rgn;
        draw_d      = opaque;
        rgb_d       = opaque ? pal_q[ram_data] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x0_q        <= 11'(SCR_W);
            y0_q        <= 11'd400;
            auto_move_q <= 1'b0;
            speed_q     <= 4'd0;
            transp_q    <= 2'd0;
            mirror_q    <= 1'b0;
            pal_q[0]    <= CD'(12'h000);
            pal_q[1]    <= CD'(12'hF00);
            pal_q[2]    <= CD'(12'h0F0);
            pal_q[3]    <= CD'(12'hFFF);
            in_rgn_d1_q <= 1'b0;
            rgb_q       <= '0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            auto_move_q <= auto_move_d;
            speed_q     <= speed_d;
            transp_q    <= transp_d;
            mirror_q    <= mirror_d;
            pal_q       <= pal_d;
            in_rgn_d1_q <= in_rgn_d1_d;
            rgb_q       <= rgb_d;
            draw_q      <= draw_d;
        end
    end

    assign rgb  = rgb_q;
    assign draw = draw_q;

endmodule
